// File: rtl/signal_pkg.sv
// rtl/signal_pkg.sv - shared types and constants for the intersection signal sequencer
package signal_pkg;

  typedef enum logic [1:0] {
    FLASH   = 2'd0,
    RUN     = 2'd1,
    PREEMPT = 2'd2
  } state_t;

  localparam int CNT_W = 5;

  // Fixed by the light decoder: it shows yellow whenever Count_out <= 3.
  localparam logic [CNT_W-1:0] YELLOW_TIME = 5'd3;

  localparam logic [1:0] POS_0 = 2'd0;
  localparam logic [1:0] POS_1 = 2'd1;
  localparam logic [1:0] POS_2 = 2'd2;
  localparam logic [1:0] POS_3 = 2'd3;

  function automatic logic [3:0] pos_onehot(input logic [1:0] pos);
    logic [3:0] m;
    m = 4'b0000;
    m[pos] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/signal_sequencer_if.sv
// rtl/signal_sequencer_if.sv - detector/request inputs and decoder-facing outputs of the sequencer
interface signal_sequencer_if;
  import signal_pkg::*;

  logic             Tick_1Hz;
  logic [3:0]       Car_Req;
  logic             Night_Mode;
  logic             Emergency;
  logic [1:0]       Emg_Pos;
  logic [1:0]       Signal_Pos;
  logic [CNT_W-1:0] Count_out;
  logic             light_out_time;

  modport master (
    output Tick_1Hz, Car_Req, Night_Mode, Emergency, Emg_Pos,
    input  Signal_Pos, Count_out, light_out_time
  );

  modport slave (
    input  Tick_1Hz, Car_Req, Night_Mode, Emergency, Emg_Pos,
    output Signal_Pos, Count_out, light_out_time
  );

endinterface

// File: rtl/signal_sequencer_rr_pick.sv
// rtl/signal_sequencer_rr_pick.sv - round-robin choice of the next approach with pending demand
module rr_pick (
  input  logic [3:0] pend,
  input  logic [1:0] cur,
  output logic [1:0] nxt,
  output logic       any
);

  // Walk offsets from farthest to nearest so the nearest pending approach after cur wins.
  always_comb begin
    nxt = cur + 2'd1;
    any = |pend;
    for (int k = 4; k >= 1; k--) begin
      if (pend[cur + 2'(k)]) begin
        nxt = cur + 2'(k);
      end
    end
  end

endmodule

// File: rtl/signal_sequencer.sv
// rtl/signal_sequencer.sv - phase timing, round-robin, preemption and flashing control for the light decoder
module signal_sequencer
  import signal_pkg::*;
#(
  parameter int GREEN_TIME    = 20,
  parameter int STARTUP_FLASH = 5
) (
  input logic                CLK,
  input logic                RST,
  signal_sequencer_if.slave  bus
);

  localparam int FW = $clog2(STARTUP_FLASH + 2);
  localparam logic [CNT_W-1:0] GREEN_CNT = CNT_W'(GREEN_TIME);
  localparam logic [FW-1:0]    FLASH_MIN = FW'(STARTUP_FLASH);

  state_t           state;
  logic [1:0]       sig_pos;
  logic [CNT_W-1:0] count;
  logic             light;
  logic [3:0]       pend;
  logic [FW-1:0]    flash_cnt;

  logic [FW-1:0]    flash_inc;
  logic [3:0]       pend_set;
  logic [3:0]       pend_acc;
  logic [1:0]       rr_nxt;
  logic             rr_any;

  rr_pick u_rr_pick (
    .pend (pend),
    .cur  (sig_pos),
    .nxt  (rr_nxt),
    .any  (rr_any)
  );

  assign flash_inc = (&flash_cnt) ? flash_cnt : flash_cnt + 1'b1;
  // Demand on the approach that already has the lights is ignored, except while flashing.
  assign pend_set  = bus.Car_Req & ((state == FLASH) ? 4'hF : ~pos_onehot(sig_pos));
  assign pend_acc  = pend | pend_set;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= FLASH;
      sig_pos   <= POS_0;
      count     <= GREEN_CNT;
      light     <= 1'b1;
      pend      <= 4'b0000;
      flash_cnt <= '0;
    end else begin
      pend <= pend_acc;
      if (bus.Tick_1Hz) begin
        case (state)
          FLASH: begin
            flash_cnt <= flash_inc;
            if (bus.Emergency) begin
              state   <= PREEMPT;
              light   <= 1'b0;
              sig_pos <= bus.Emg_Pos;
              count   <= GREEN_CNT;
              pend    <= pend_acc & ~pos_onehot(bus.Emg_Pos);
            end else if (flash_inc >= FLASH_MIN && !bus.Night_Mode) begin
              state   <= RUN;
              light   <= 1'b0;
              sig_pos <= POS_0;
              count   <= GREEN_CNT;
              pend    <= pend_acc & ~pos_onehot(POS_0);
            end
          end
          default: begin
            if (bus.Emergency && bus.Emg_Pos == sig_pos) begin
              state <= PREEMPT;
              count <= GREEN_CNT;
            end else if (count == '0) begin
              if (bus.Emergency) begin
                state   <= PREEMPT;
                sig_pos <= bus.Emg_Pos;
                count   <= GREEN_CNT;
                pend    <= pend_acc & ~pos_onehot(bus.Emg_Pos);
              end else if (bus.Night_Mode) begin
                state     <= FLASH;
                light     <= 1'b1;
                flash_cnt <= FLASH_MIN;
                count     <= GREEN_CNT;
              end else begin
                state   <= RUN;
                sig_pos <= rr_nxt;
                count   <= GREEN_CNT;
                pend    <= pend_acc & ~pos_onehot(rr_nxt);
              end
            end else if (bus.Emergency) begin
              // Preemption toward another approach cuts straight to yellow.
              count <= (count > YELLOW_TIME) ? YELLOW_TIME : count - 1'b1;
            end else begin
              state <= RUN;
              if (!(count == YELLOW_TIME + 1'b1 && !rr_any && !bus.Night_Mode)) begin
                count <= count - 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign bus.Signal_Pos     = sig_pos;
  assign bus.Count_out      = count;
  assign bus.light_out_time = light;

endmodule

// File: tb/tb_signal_sequencer.sv
// tb/tb_signal_sequencer.sv - table-driven scoreboard bench for signal_sequencer
module tb_signal_sequencer;

  logic clk;
  logic rst;

  signal_sequencer_if bus ();

  signal_sequencer #(
    .GREEN_TIME    (20),
    .STARTUP_FLASH (5)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         n;
    logic [3:0] car;
    logic       night;
    logic       emg;
    logic [1:0] epos;
    logic       chk_pc;
    logic [1:0] pos;
    logic [4:0] cnt;
    logic       lt;
  } vec_t;

  typedef struct {
    string      name;
    logic       chk_pc;
    logic [1:0] pos;
    logic [4:0] cnt;
    logic       lt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  localparam int NV = 27;
  vec_t vecs[NV];

  function automatic vec_t mk(string name, int n, logic [3:0] car, logic night, logic emg,
                              logic [1:0] epos, logic chk_pc, logic [1:0] pos, logic [4:0] cnt,
                              logic lt);
    vec_t v;
    v.name = name; v.n = n; v.car = car; v.night = night; v.emg = emg; v.epos = epos;
    v.chk_pc = chk_pc; v.pos = pos; v.cnt = cnt; v.lt = lt;
    return v;
  endfunction

  task automatic push_exp(string name, logic chk_pc, logic [1:0] pos, logic [4:0] cnt, logic lt);
    exp_t e;
    e.name = name; e.chk_pc = chk_pc; e.pos = pos; e.cnt = cnt; e.lt = lt;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: got nothing to compare, want one queued entry");
      return;
    end
    e = sb.pop_front();
    if (bus.light_out_time !== e.lt ||
        (e.chk_pc && (bus.Signal_Pos !== e.pos || bus.Count_out !== e.cnt))) begin
      bad++;
      $display("FAIL %s: got pos=%0d cnt=%0d light=%0d, want pos=%0d cnt=%0d light=%0d%s",
               e.name, bus.Signal_Pos, bus.Count_out, bus.light_out_time,
               e.pos, e.cnt, e.lt, e.chk_pc ? "" : " (pos/cnt unchecked)");
    end
  endtask

  // One tick pulse followed by idle cycles; outputs are sampled after the idle cycles.
  task automatic do_tick();
    @(negedge clk); bus.Tick_1Hz = 1'b1;
    @(negedge clk); bus.Tick_1Hz = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_car(logic [3:0] car);
    @(negedge clk); bus.Car_Req = car;
    @(negedge clk); bus.Car_Req = 4'b0000;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk("hold_at_4",          3, 4'b0000, 0, 0, 2'd0, 1, 2'd0,  5'd4, 0);
    vecs[1]  = mk("yellow_on_demand",   1, 4'b0100, 0, 0, 2'd0, 1, 2'd0,  5'd3, 0);
    vecs[2]  = mk("yellow_end",         3, 4'b0000, 0, 0, 2'd0, 1, 2'd0,  5'd0, 0);
    vecs[3]  = mk("phase_to_2",         1, 4'b0000, 0, 0, 2'd0, 1, 2'd2, 5'd20, 0);
    vecs[4]  = mk("count_to_4_pos2",   16, 4'b0000, 0, 0, 2'd0, 1, 2'd2,  5'd4, 0);
    vecs[5]  = mk("hold_pend_cleared",  2, 4'b0000, 0, 0, 2'd0, 1, 2'd2,  5'd4, 0);
    vecs[6]  = mk("yellow_multi_req",   4, 4'b1011, 0, 0, 2'd0, 1, 2'd2,  5'd0, 0);
    vecs[7]  = mk("rr_to_3",            1, 4'b0000, 0, 0, 2'd0, 1, 2'd3, 5'd20, 0);
    vecs[8]  = mk("rr_to_0",           21, 4'b0000, 0, 0, 2'd0, 1, 2'd0, 5'd20, 0);
    vecs[9]  = mk("rr_to_1",           21, 4'b0000, 0, 0, 2'd0, 1, 2'd1, 5'd20, 0);
    vecs[10] = mk("count_to_15",        5, 4'b0000, 0, 0, 2'd0, 1, 2'd1, 5'd15, 0);
    vecs[11] = mk("emg_force_yellow",   1, 4'b0000, 0, 1, 2'd3, 1, 2'd1,  5'd3, 0);
    vecs[12] = mk("emg_yellow_end",     3, 4'b0000, 0, 1, 2'd3, 1, 2'd1,  5'd0, 0);
    vecs[13] = mk("preempt_switch",     1, 4'b0000, 0, 1, 2'd3, 1, 2'd3, 5'd20, 0);
    vecs[14] = mk("preempt_hold",       3, 4'b0000, 0, 1, 2'd3, 1, 2'd3, 5'd20, 0);
    vecs[15] = mk("preempt_release",    1, 4'b0000, 0, 0, 2'd0, 1, 2'd3, 5'd19, 0);
    vecs[16] = mk("post_release",       1, 4'b0000, 0, 0, 2'd0, 1, 2'd3, 5'd18, 0);
    vecs[17] = mk("night_countdown",   18, 4'b0000, 1, 0, 2'd0, 1, 2'd3,  5'd0, 0);
    vecs[18] = mk("night_flash",        1, 4'b0000, 1, 0, 2'd0, 0, 2'd0,  5'd0, 1);
    vecs[19] = mk("night_flash_stay",   2, 4'b0000, 1, 0, 2'd0, 0, 2'd0,  5'd0, 1);
    vecs[20] = mk("night_release",      1, 4'b0000, 0, 0, 2'd0, 1, 2'd0, 5'd20, 0);
    vecs[21] = mk("count_to_10",       10, 4'b0000, 0, 0, 2'd0, 1, 2'd0, 5'd10, 0);
    vecs[22] = mk("preempt_same_pos",   2, 4'b0000, 0, 1, 2'd0, 1, 2'd0, 5'd20, 0);
    vecs[23] = mk("same_pos_release",   1, 4'b0000, 0, 0, 2'd0, 1, 2'd0, 5'd19, 0);
    vecs[24] = mk("emg_to_2_yellow",    1, 4'b0000, 0, 1, 2'd2, 1, 2'd0,  5'd3, 0);
    vecs[25] = mk("emg_to_2_switch",    4, 4'b0000, 0, 1, 2'd2, 1, 2'd2, 5'd20, 0);
    vecs[26] = mk("emg_to_2_release",   1, 4'b0000, 0, 0, 2'd0, 1, 2'd2, 5'd19, 0);

    rst            = 1'b1;
    bus.Tick_1Hz   = 1'b0;
    bus.Car_Req    = 4'b0000;
    bus.Night_Mode = 1'b0;
    bus.Emergency  = 1'b0;
    bus.Emg_Pos    = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    push_exp("reset_state", 1, 2'd0, 5'd20, 1);
    check_out();

    for (int k = 1; k <= 4; k++) begin
      push_exp("startup_flash", 1, 2'd0, 5'd20, 1);
      do_tick();
      check_out();
    end
    push_exp("startup_exit", 1, 2'd0, 5'd20, 0);
    do_tick();
    check_out();

    for (int k = 1; k <= 16; k++) begin
      push_exp("countdown_pos0", 1, 2'd0, 5'(20 - k), 0);
      do_tick();
      check_out();
    end

    for (int i = 0; i < NV; i++) begin
      bus.Night_Mode = vecs[i].night;
      bus.Emergency  = vecs[i].emg;
      bus.Emg_Pos    = vecs[i].epos;
      push_exp(vecs[i].name, vecs[i].chk_pc, vecs[i].pos, vecs[i].cnt, vecs[i].lt);
      if (vecs[i].car != 4'b0000) pulse_car(vecs[i].car);
      repeat (vecs[i].n) do_tick();
      check_out();
    end

    // Asynchronous reset between clock edges must act immediately.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    push_exp("async_reset", 1, 2'd0, 5'd20, 1);
    check_out();
    @(negedge clk);
    rst = 1'b0;

    bus.Emergency = 1'b1;
    bus.Emg_Pos   = 2'd1;
    push_exp("flash_emergency", 1, 2'd1, 5'd20, 0);
    do_tick();
    check_out();

    bus.Emergency = 1'b0;
    push_exp("flash_emg_release", 1, 2'd1, 5'd19, 0);
    do_tick();
    check_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
